axi4_lite_wr_arbiter: RTL and testbench
=======================================

Name: axi4_lite_wr_arbiter

Overview:
- Two-master to one-slave AXI4-Lite write-path arbiter.
- Shares one register slave, such as the skid-buffered AXI4-Lite register block, between two write masters (e.g. CPU bridge and DMA config engine).
- Grants one full write transaction (AW + W + B) at a time.
- Round-robin by default; fixed priority when the optional macro is defined.

Parameters:
ADDRESS_SIZE, 5, AW address width per master and slave
DATA_SIZE, 32, write data width; strobe width DATA_SIZE/8

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axi_awaddr  in  2*ADDRESS_SIZE  master i at slice i
s_axi_awvalid  in  2  per-master AW valid (= request)
s_axi_awready  out  2  per-master AW ready
s_axi_wdata  in  2*DATA_SIZE  per-master write data
s_axi_wstrb  in  2*(DATA_SIZE/8)  per-master strobes
s_axi_wvalid  in  2  per-master W valid
s_axi_wready  out  2  per-master W ready
s_axi_bresp  out  4  per-master response, 2 bits each
s_axi_bvalid  out  2  per-master B valid
s_axi_bready  in  2  per-master B ready
m_axi_awaddr  out  ADDRESS_SIZE  to slave
m_axi_awvalid  out  1  to slave
m_axi_awready  in  1  from slave
m_axi_wdata  out  DATA_SIZE  to slave
m_axi_wstrb  out  DATA_SIZE/8  to slave
m_axi_wvalid  out  1  to slave
m_axi_wready  in  1  from slave
m_axi_bresp  in  2  from slave
m_axi_bvalid  in  1  from slave
m_axi_bready  out  1  to slave

Behaviour:
- One clock, aclk; reset aresetn is synchronous, active-low.
- Registered state: FSM IDLE/XFER/RESP, gnt (1b), last (1b), aw_done, w_done.
- Reset values: state IDLE, gnt 0, last 1, done flags 0.
- All valid/ready outputs are 0 while in reset and in IDLE. s_axi_bresp = 0.
- Reset mid-transaction aborts silently to IDLE; no B is returned.
- IDLE:
  - req = s_axi_awvalid. wvalid alone is not a request.
  - One requester: grant it.
  - Both requesting: grant ~last.
  - Load gnt and go to XFER. No ready is asserted in the grant cycle (1-cycle arbitration latency).
- XFER, AW channel:
  - m_axi_awvalid = s_axi_awvalid[gnt] & ~aw_done.
  - s_axi_awready[gnt] = m_axi_awready & ~aw_done.
- XFER, W channel: same rule, using w_done.
- XFER, handshake order: AW and W complete independently, in either order or in the same cycle. Each sets its done flag on handshake.
- XFER exit: when both are complete (counting a same-cycle final handshake), clear the flags and go to RESP.
- RESP:
  - s_axi_bvalid[gnt] = m_axi_bvalid; m_axi_bready = s_axi_bready[gnt]; bresp slice gnt = m_axi_bresp.
  - On the B handshake: last <= gnt, go to IDLE.
- Non-granted master: all readies, bvalid and bresp are 0 for the whole transaction.
- Slave-side addr/data/strb are always muxed from slice gnt (never X); only the valids are gated.
- Throughput: at most one write per 3 cycles with a zero-wait slave (IDLE, XFER, RESP).
- bresp values are passed through unchanged (OKAY/SLVERR/DECERR).

Optional Feature:
- Macro AXI_WR_ARB_FIXED_PRIO_EN.
- Defined: on contention master 0 always wins; last is not used (may be optimised away). Master 1 can starve.
- Undefined: round-robin as above.

Test Plan:
- Reset, and reset mid-transaction:
  - Hold aresetn=0 for 3 cycles with both s_axi_awvalid=1 -> all ready/valid outputs 0. After release, master 0 is granted first (m_axi_awaddr = slice 0).
  - Assert aresetn=0 during RESP -> outputs 0 next cycle, FSM in IDLE.
- Single master: master 1 writes addr 0x04, data 0xDEADBEEF, strb 0xF; slave returns OKAY -> m_axi_awaddr=0x04, m_axi_wdata=0xDEADBEEF; s_axi_bvalid=2'b10 with bresp[3:2]=2'b00; s_axi_awready[0] stays 0.
- Contention: both masters issue 4 back-to-back writes -> grant order 0,1,0,1,0,1,0,1. With AXI_WR_ARB_FIXED_PRIO_EN: 0,0,0,0,1,1,1,1.
- AW/W skew: master 0 awvalid at cycle n, wvalid at n+5, slave always ready -> AW accepted at n+1; m_axi_wvalid low until n+5; no RESP before W completes. Then repeat with W before AW.
- Backpressure: slave delays bvalid 10 cycles with bresp=2'b10, then master holds bready=0 for 3 cycles -> grant held throughout; master 1 awready stays 0; SLVERR delivered to master 0 and bvalid held until bready.

Source files
------------

// File: rtl/axi4_lite_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_wr_arbiter
// Purpose  : Two-master to one-slave AXI4-Lite write-path arbiter. One full
//            write transaction (AW + W + B) is granted at a time. Arbitration
//            is round-robin; defining AXI_WR_ARB_FIXED_PRIO_EN switches it
//            to fixed priority (master 0 always wins on contention).
// Ports    : aclk / aresetn        clock, synchronous active-low reset
//            s_axi_*               two master-facing ports, master i at slice i
//            m_axi_*               single slave-facing port
// Revision : 1.0  initial release
// ============================================================================
module axi4_lite_wr_arbiter #(
   parameter int ADDRESS_SIZE = 5,
   parameter int DATA_SIZE    = 32
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [2*ADDRESS_SIZE-1:0]    s_axi_awaddr,
   input  logic [1:0]                   s_axi_awvalid,
   output logic [1:0]                   s_axi_awready,
   input  logic [2*DATA_SIZE-1:0]       s_axi_wdata,
   input  logic [2*(DATA_SIZE/8)-1:0]   s_axi_wstrb,
   input  logic [1:0]                   s_axi_wvalid,
   output logic [1:0]                   s_axi_wready,
   output logic [3:0]                   s_axi_bresp,
   output logic [1:0]                   s_axi_bvalid,
   input  logic [1:0]                   s_axi_bready,
   output logic [ADDRESS_SIZE-1:0]      m_axi_awaddr,
   output logic                         m_axi_awvalid,
   input  logic                         m_axi_awready,
   output logic [DATA_SIZE-1:0]         m_axi_wdata,
   output logic [DATA_SIZE/8-1:0]       m_axi_wstrb,
   output logic                         m_axi_wvalid,
   input  logic                         m_axi_wready,
   input  logic [1:0]                   m_axi_bresp,
   input  logic                         m_axi_bvalid,
   output logic                         m_axi_bready
);

   localparam int STRB_SIZE = DATA_SIZE / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   gnt, gnt_nxt;
   logic   aw_done, aw_done_nxt;
   logic   w_done, w_done_nxt;
   logic   pick;
   logic   sel_awvalid, sel_wvalid, sel_bready;
   logic   aw_hs, w_hs;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
   // Master 1 only wins when master 0 is not requesting.
   assign pick = ~s_axi_awvalid[0];
`else
   logic   last, last_nxt;
   // On contention the master that was not served last goes next.
   assign pick = (&s_axi_awvalid) ? ~last : s_axi_awvalid[1];
`endif

   // Payload is always muxed from the granted slice; only valids are gated.
   assign m_axi_awaddr = gnt ? s_axi_awaddr[2*ADDRESS_SIZE-1:ADDRESS_SIZE]
                             : s_axi_awaddr[ADDRESS_SIZE-1:0];
   assign m_axi_wdata  = gnt ? s_axi_wdata[2*DATA_SIZE-1:DATA_SIZE]
                             : s_axi_wdata[DATA_SIZE-1:0];
   assign m_axi_wstrb  = gnt ? s_axi_wstrb[2*STRB_SIZE-1:STRB_SIZE]
                             : s_axi_wstrb[STRB_SIZE-1:0];

   assign sel_awvalid  = gnt ? s_axi_awvalid[1] : s_axi_awvalid[0];
   assign sel_wvalid   = gnt ? s_axi_wvalid[1]  : s_axi_wvalid[0];
   assign sel_bready   = gnt ? s_axi_bready[1]  : s_axi_bready[0];

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
         last    <= 1'b1;
`endif
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
         last    <= last_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      aw_done_nxt   = aw_done;
      w_done_nxt    = w_done;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
      last_nxt      = last;
`endif
      aw_hs         = 1'b0;
      w_hs          = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      s_axi_awready = 2'b00;
      s_axi_wready  = 2'b00;
      s_axi_bvalid  = 2'b00;
      s_axi_bresp   = 4'b0000;

      case (state)
         IDLE: begin
            // Grant cycle: no ready is raised here, the grant takes effect next cycle.
            if (|s_axi_awvalid) begin
               gnt_nxt   = pick;
               state_nxt = XFER;
            end
         end

         XFER: begin
            m_axi_awvalid      = sel_awvalid & ~aw_done;
            s_axi_awready[gnt] = m_axi_awready & ~aw_done;
            m_axi_wvalid       = sel_wvalid & ~w_done;
            s_axi_wready[gnt]  = m_axi_wready & ~w_done;
            aw_hs              = m_axi_awvalid & m_axi_awready;
            w_hs               = m_axi_wvalid & m_axi_wready;
            // AW and W finish independently; leave once both are in, counting
            // a final handshake that lands this very cycle.
            if ((aw_done | aw_hs) & (w_done | w_hs)) begin
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               state_nxt   = RESP;
            end else begin
               aw_done_nxt = aw_done | aw_hs;
               w_done_nxt  = w_done | w_hs;
            end
         end

         RESP: begin
            s_axi_bvalid[gnt] = m_axi_bvalid;
            m_axi_bready      = sel_bready;
            if (gnt) begin
               s_axi_bresp[3:2] = m_axi_bresp;
            end else begin
               s_axi_bresp[1:0] = m_axi_bresp;
            end
            if (m_axi_bvalid & sel_bready) begin
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
               last_nxt  = gnt;
`endif
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Keep every handshake output quiet while reset is held.
      if (!aresetn) begin
         m_axi_awvalid = 1'b0;
         m_axi_wvalid  = 1'b0;
         m_axi_bready  = 1'b0;
         s_axi_awready = 2'b00;
         s_axi_wready  = 2'b00;
         s_axi_bvalid  = 2'b00;
         s_axi_bresp   = 4'b0000;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_wr_arbiter
// Purpose  : Self-checking bench for axi4_lite_wr_arbiter: directed reset,
//            single-master, AW/W skew and backpressure steps, then randomized
//            two-master traffic checked against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_wr_arbiter;

   localparam int A = 5;
   localparam int D = 32;
   localparam int S = D / 8;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic [2*A-1:0] s_axi_awaddr;
   logic [1:0]     s_axi_awvalid;
   logic [1:0]     s_axi_awready;
   logic [2*D-1:0] s_axi_wdata;
   logic [2*S-1:0] s_axi_wstrb;
   logic [1:0]     s_axi_wvalid;
   logic [1:0]     s_axi_wready;
   logic [3:0]     s_axi_bresp;
   logic [1:0]     s_axi_bvalid;
   logic [1:0]     s_axi_bready;
   logic [A-1:0]   m_axi_awaddr;
   logic           m_axi_awvalid;
   logic           m_axi_awready;
   logic [D-1:0]   m_axi_wdata;
   logic [S-1:0]   m_axi_wstrb;
   logic           m_axi_wvalid;
   logic           m_axi_wready;
   logic [1:0]     m_axi_bresp;
   logic           m_axi_bvalid;
   logic           m_axi_bready;

   axi4_lite_wr_arbiter #(.ADDRESS_SIZE(A), .DATA_SIZE(D)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready)
   );

   always #5 aclk = ~aclk;

   // All handshake-type outputs in one vector for "everything quiet" checks.
   logic [12:0] outs;
   assign outs = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                  m_axi_awvalid, m_axi_wvalid, m_axi_bready};

   int tests = 0;
   int fails = 0;
   bit model_last = 1'b1;   // master served by the most recent completed write

   // Transaction store for the randomized phase.
   logic [A-1:0] ta [2][32];
   logic [D-1:0] td [2][32];
   logic [S-1:0] ts [2][32];
   int           head [2];
   int           wcnt [2];
   bit           wpend [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_m(input int m, input logic [A-1:0] a, input logic [D-1:0] d,
                        input logic [S-1:0] s);
      s_axi_awaddr[m*A +: A] = a;
      s_axi_wdata[m*D +: D]  = d;
      s_axi_wstrb[m*S +: S]  = s;
   endtask

   // Arbitration rule at transaction level: who is served next given who still has work.
   function automatic int pick_next(input int n, input int cur);
      bit p0, p1;
      p0 = head[0] < n;
      p1 = head[1] < n;
      if (p0 && p1) begin
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
         return 0;
`else
         return model_last ? 0 : 1;
`endif
      end
      if (p1) return 1;
      if (p0) return 0;
      return cur;
   endfunction

   task automatic start_m(input int m, input bit fast);
      set_m(m, ta[m][head[m]], td[m][head[m]], ts[m][head[m]]);
      s_axi_awvalid[m] = 1'b1;
      wcnt[m] = fast ? 0 : int'($urandom_range(0, 3));
      if (wcnt[m] == 0) begin
         s_axi_wvalid[m] = 1'b1;
         wpend[m] = 1'b0;
      end else begin
         wpend[m] = 1'b1;
      end
   endtask

   // Both masters keep a write pending back-to-back; the slave and the
   // masters' B acceptance are randomized unless 'fast'.
   task automatic run_engine(input int n, input bit fast);
      int own, oth, bcnt;
      bit got_aw, got_w, hs_aw, hs_w, hs_sb, mb, ms_aw;
      logic [1:0] exp_br;
      for (int m = 0; m < 2; m++) begin
         head[m] = 0;
         for (int i = 0; i < n; i++) begin
            ta[m][i] = A'($urandom);
            td[m][i] = $urandom;
            ts[m][i] = S'($urandom);
         end
      end
      got_aw = 0; got_w = 0; bcnt = -1; exp_br = 2'b00;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
      s_axi_bready = 2'b11;
      start_m(0, fast);
      start_m(1, fast);
      own = pick_next(n, 0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge aclk);
         oth = 1 - own;
         chk("quiet_other", {59'd0, s_axi_awready[oth], s_axi_wready[oth], s_axi_bvalid[oth],
                             s_axi_bresp[oth*2 +: 2]}, 64'd0);
         if (m_axi_awvalid) begin
            chk("aw_once", {63'd0, got_aw}, 64'd0);
            chk("rnd_awaddr", {59'd0, m_axi_awaddr}, {59'd0, ta[own][head[own]]});
         end
         if (m_axi_wvalid) begin
            chk("w_once", {63'd0, got_w}, 64'd0);
            chk("rnd_wdata", {28'd0, m_axi_wstrb, m_axi_wdata},
                {28'd0, ts[own][head[own]], td[own][head[own]]});
         end
         hs_aw = m_axi_awvalid & m_axi_awready;
         hs_w  = m_axi_wvalid & m_axi_wready;
         hs_sb = m_axi_bvalid & m_axi_bready;
         ms_aw = s_axi_awvalid[own] & s_axi_awready[own];
         mb    = s_axi_bvalid[own] & s_axi_bready[own];
         if (hs_aw || ms_aw) chk("aw_pair", {63'd0, ms_aw}, {63'd0, hs_aw});
         if (s_axi_bvalid[own]) begin
            chk("b_after_aw_w", {62'd0, got_aw, got_w}, 64'd3);
            chk("rnd_bresp", {62'd0, s_axi_bresp[own*2 +: 2]}, {62'd0, exp_br});
         end
         if (mb) chk("b_pair", {63'd0, hs_sb}, 64'd1);
         step();
         if (hs_aw) begin got_aw = 1; s_axi_awvalid[own] = 1'b0; end
         if (hs_w)  begin got_w = 1;  s_axi_wvalid[own] = 1'b0; end
         if (hs_sb) begin m_axi_bvalid = 1'b0; got_aw = 0; got_w = 0; bcnt = -1; end
         if (mb) begin
            head[own]++;
            model_last = own[0];
            if (head[own] < n) start_m(own, fast);
            own = pick_next(n, own);
         end
         for (int m = 0; m < 2; m++) begin
            if (wpend[m]) begin
               if (wcnt[m] <= 1) begin
                  s_axi_wvalid[m] = 1'b1;
                  wpend[m] = 1'b0;
               end else begin
                  wcnt[m]--;
               end
            end
         end
         if (got_aw && got_w && !m_axi_bvalid) begin
            if (bcnt < 0) bcnt = fast ? 0 : int'($urandom_range(0, 4));
            if (bcnt == 0) begin
               exp_br = 2'($urandom);
               m_axi_bvalid = 1'b1;
               m_axi_bresp = exp_br;
            end else begin
               bcnt--;
            end
         end
         m_axi_awready = fast ? 1'b1 : 1'($urandom);
         m_axi_wready  = fast ? 1'b1 : 1'($urandom);
         s_axi_bready  = fast ? 2'b11 : 2'($urandom);
         if (head[0] >= n && head[1] >= n) break;
      end
      chk("engine_done", {32'(head[0]), 32'(head[1])}, {32'(n), 32'(n)});
      s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; s_axi_bready = 2'b00;
      m_axi_bvalid = 1'b0;
   endtask

   initial begin
      // ---------------- reset held with both masters requesting ----------------
      aresetn = 1'b0;
      s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_awvalid = 2'b11; s_axi_wvalid = 2'b11; s_axi_bready = 2'b00;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      set_m(0, 5'h0A, 32'h1111_0000, 4'h3);
      set_m(1, 5'h15, 32'h2222_0000, 4'hC);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge aclk);
         chk("rst_hold_outs", {51'd0, outs}, 64'd0);
      end
      step();
      aresetn = 1'b1;
      @(negedge aclk);
      chk("grant_cycle_quiet", {51'd0, outs}, 64'd0);
      step();
      @(negedge aclk);
      chk("first_gnt_awaddr", {59'd0, m_axi_awaddr}, 64'h0A);
      chk("first_gnt_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
      chk("first_gnt_awready", {62'd0, s_axi_awready}, 64'd1);
      step();
      s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      @(negedge aclk);
      chk("pre_rst_bvalid", {62'd0, s_axi_bvalid}, 64'd1);
      // ---------------- reset during RESP ----------------
      step();
      aresetn = 1'b0;
      @(negedge aclk);
      chk("rst_mid_outs", {51'd0, outs}, 64'd0);
      step();
      set_m(1, 5'h04, 32'hDEAD_BEEF, 4'hF);
      s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10; s_axi_bready = 2'b10;
      m_axi_bvalid = 1'b0;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("idle_after_rst", {51'd0, outs}, 64'd0);
      // ---------------- single master 1 ----------------
      step();
      @(negedge aclk);
      chk("m1_awaddr", {59'd0, m_axi_awaddr}, 64'h04);
      chk("m1_wdata", {28'd0, m_axi_wstrb, m_axi_wdata}, {28'd0, 4'hF, 32'hDEAD_BEEF});
      chk("m1_valids", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
      chk("m1_readies", {60'd0, s_axi_awready, s_axi_wready}, 64'b1010);
      step();
      s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      @(negedge aclk);
      chk("m1_bvalid", {62'd0, s_axi_bvalid}, 64'b10);
      chk("m1_bresp", {60'd0, s_axi_bresp}, 64'd0);
      chk("m1_bready_m0_awready", {62'd0, m_axi_bready, s_axi_awready[0]}, 64'b10);
      step();
      m_axi_bvalid = 1'b0;
      model_last = 1'b1;
      @(negedge aclk);
      chk("m1_done_idle", {62'd0, s_axi_bvalid}, 64'd0);
      // ---------------- AW then W five cycles later ----------------
      step();
      set_m(0, 5'h08, 32'hA5A5_0001, 4'hF);
      s_axi_awvalid = 2'b01; s_axi_wvalid = 2'b00; s_axi_bready = 2'b01;
      @(negedge aclk);
      chk("skew_grant_cycle", {63'd0, m_axi_awvalid}, 64'd0);
      step();
      @(negedge aclk);
      chk("skew_aw_n1", {60'd0, m_axi_awvalid, s_axi_awready, m_axi_wvalid}, 64'b1010);
      step();
      s_axi_awvalid = 2'b00;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01;   // early B must not leak through
      for (int k = 2; k <= 4; k++) begin
         @(negedge aclk);
         chk("skew_wait_w", {59'd0, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_bready}, 64'd0);
         step();
         if (k == 4) s_axi_wvalid = 2'b01;
      end
      @(negedge aclk);
      chk("skew_w_n5", {59'd0, m_axi_wvalid, s_axi_wready, s_axi_bvalid}, 64'b10100);
      step();
      s_axi_wvalid = 2'b00;
      @(negedge aclk);
      chk("skew_resp", {58'd0, s_axi_bvalid, s_axi_bresp}, {58'd0, 2'b01, 4'b0001});
      step();
      m_axi_bvalid = 1'b0;
      model_last = 1'b0;
      // ---------------- W before AW ----------------
      set_m(0, 5'h1C, 32'h0BAD_F00D, 4'h5);
      s_axi_wvalid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("wfirst_no_req", {61'd0, m_axi_wvalid, s_axi_wready}, 64'd0);
         step();
         if (k == 2) s_axi_awvalid = 2'b01;
      end
      @(negedge aclk);
      chk("wfirst_grant_cycle", {63'd0, m_axi_wvalid}, 64'd0);
      step();
      m_axi_awready = 1'b0;
      @(negedge aclk);
      chk("wfirst_w_xfer", {58'd0, m_axi_wvalid, s_axi_wready, m_axi_awvalid, s_axi_awready},
          64'b101100);
      step();
      s_axi_wvalid = 2'b00; m_axi_awready = 1'b1;
      @(negedge aclk);
      chk("wfirst_aw_xfer", {58'd0, m_axi_wvalid, m_axi_awvalid, s_axi_awready, s_axi_bvalid},
          64'b010100);
      step();
      s_axi_awvalid = 2'b00;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      @(negedge aclk);
      chk("wfirst_resp", {62'd0, s_axi_bvalid}, 64'b01);
      step();
      m_axi_bvalid = 1'b0;
      model_last = 1'b0;
      // ---------------- backpressure on B ----------------
      set_m(0, 5'h10, 32'hCAFE_0010, 4'hF);
      s_axi_awvalid = 2'b01; s_axi_wvalid = 2'b01; s_axi_bready = 2'b00;
      @(negedge aclk);
      step();
      @(negedge aclk);
      chk("bp_awaddr", {59'd0, m_axi_awaddr}, 64'h10);
      step();
      s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00;
      set_m(1, 5'h11, 32'hBEEF_0011, 4'hA);
      s_axi_awvalid[1] = 1'b1; s_axi_wvalid[1] = 1'b1; s_axi_bready = 2'b10;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         chk("bp_slave_delay", {55'd0, s_axi_bvalid, s_axi_awready, s_axi_wready,
                                m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'd0);
         step();
         if (k == 9) begin m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("bp_master_hold", {55'd0, s_axi_bvalid, s_axi_bresp, m_axi_bready, s_axi_awready},
             {55'd0, 2'b01, 4'b0010, 1'b0, 2'b00});
         step();
         if (k == 2) s_axi_bready = 2'b11;
      end
      @(negedge aclk);
      chk("bp_release", {57'd0, s_axi_bvalid, s_axi_bresp, m_axi_bready},
          {57'd0, 2'b01, 4'b0010, 1'b1});
      step();
      m_axi_bvalid = 1'b0;
      model_last = 1'b0;
      @(negedge aclk);
      chk("bp_next_grant_cycle", {51'd0, outs}, 64'd0);
      step();
      @(negedge aclk);
      chk("bp_m1_payload", {23'd0, m_axi_awaddr, m_axi_wdata, s_axi_awready},
          {23'd0, 5'h11, 32'hBEEF_0011, 2'b10});
      step();
      s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; s_axi_bready = 2'b10;
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      @(negedge aclk);
      chk("bp_m1_bvalid", {62'd0, s_axi_bvalid}, 64'b10);
      step();
      m_axi_bvalid = 1'b0;
      model_last = 1'b1;
      // ---------------- contention, then randomized traffic ----------------
      run_engine(4, 1'b1);
      run_engine(16, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
